syn_lifo_param: RTL and testbench

Parametrised synchronous LIFO stack, successor to the fixed-size stack in the memory library. Adds configurable depth, occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, same-cycle push/pop exchange, and a registered pop-valid strobe. Used as local scratch storage wherever last-in/first-out ordering is needed (return-address stacks, expression evaluation, undo buffers).

---
 rtl/syn_lifo_pkg.sv | 18 +
 rtl/lifo_regfile.sv | 26 ++
 rtl/syn_lifo_param.sv | 156 +++++++++++++++
 tb/tb_syn_lifo_param.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/syn_lifo_pkg.sv
// Shared types and helpers for the syn_lifo_param stack.
// Holds the op-decode enum and the occupancy-count width function.
package syn_lifo_pkg;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_XCHG,
    OP_BYPASS,
    OP_FLUSH
  } op_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lifo_regfile.sv
// Stack storage: depth x data_width registers, one synchronous write port
// and one combinational read port (the top-of-stack word).
module lifo_regfile #(
  parameter int data_width = 8,
  parameter int depth      = 8,
  parameter int AW         = $clog2(depth)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [data_width-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [data_width-1:0] rdata_o
);

  logic [data_width-1:0] mem_q [depth];

  // NOTE: storage has no reset; stale contents are never visible because
  // reads are only meaningful below the stack pointer, which does reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/syn_lifo_param.sv
// Parametrised synchronous LIFO with occupancy, threshold flags, flush,
// push/pop exchange and registered pop data. Define SYN_LIFO_ERR_EN to get
// sticky overflow/underflow flags; otherwise ovf/udf are constant 0.
module syn_lifo_param
  import syn_lifo_pkg::*;
#(
  parameter int data_width = 8,
  parameter int depth      = 8,
  parameter int af_margin  = 1,
  parameter int ae_margin  = 1
) (
  input  logic                            clk,
  input  logic                            clr,
  input  logic                            flush,
  input  logic                            push,
  input  logic                            pop,
  input  logic [data_width-1:0]           data_in,
  output logic [data_width-1:0]           data_out,
  output logic                            pop_valid,
  output logic [cnt_width(depth)-1:0]     count,
  output logic                            full,
  output logic                            empty,
  output logic                            almost_full,
  output logic                            almost_empty,
  output logic                            ovf,
  output logic                            udf
);

  localparam int CW    = cnt_width(depth);
  localparam int AW    = $clog2(depth);
  localparam int AF_TH = (af_margin >= depth) ? 0 : depth - af_margin;
  localparam int AE_TH = (ae_margin >= depth) ? depth : ae_margin;

  localparam logic [CW-1:0] DEPTH_C = CW'(depth);
  localparam logic [CW-1:0] AF_TH_C = CW'(AF_TH);
  localparam logic [CW-1:0] AE_TH_C = CW'(AE_TH);

  logic [CW-1:0]         sp_q, sp_d, sp_m1;
  logic [data_width-1:0] dout_q, dout_d;
  logic                  pv_q, pv_d;
  logic                  ovf_evt, udf_evt;
  logic                  we;
  logic [AW-1:0]         waddr;
  logic [data_width-1:0] top_word;
  op_e                   op;

  assign sp_m1 = sp_q - 1'b1;
  assign empty = (sp_q == '0);
  assign full  = (sp_q == DEPTH_C);

  // Full push and empty pop decay to OP_NONE but still raise an error event.
  always_comb begin
    op      = OP_NONE;
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    if (flush)                op = OP_FLUSH;
    else if (push && pop)     op = empty ? OP_BYPASS : OP_XCHG;
    else if (push) begin
      if (full) ovf_evt = 1'b1;
      else      op      = OP_PUSH;
    end else if (pop) begin
      if (empty) udf_evt = 1'b1;
      else       op      = OP_POP;
    end
  end

  always_comb begin
    sp_d   = sp_q;
    dout_d = dout_q;
    pv_d   = 1'b0;
    we     = 1'b0;
    waddr  = sp_q[AW-1:0];
    unique case (op)
      OP_FLUSH:  sp_d = '0;
      OP_PUSH: begin
        we   = 1'b1;
        sp_d = sp_q + 1'b1;
      end
      OP_POP: begin
        dout_d = top_word;
        pv_d   = 1'b1;
        sp_d   = sp_m1;
      end
      OP_XCHG: begin
        dout_d = top_word;
        pv_d   = 1'b1;
        we     = 1'b1;
        waddr  = sp_m1[AW-1:0];
      end
      OP_BYPASS: begin
        dout_d = data_in;
        pv_d   = 1'b1;
      end
      default: ;
    endcase
  end

  lifo_regfile #(
    .data_width(data_width),
    .depth     (depth),
    .AW        (AW)
  ) u_regfile (
    .clk    (clk),
    .we_i   (we),
    .waddr_i(waddr),
    .wdata_i(data_in),
    .raddr_i(sp_m1[AW-1:0]),
    .rdata_o(top_word)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed by the combinational blocks above.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sp_q   <= '0;
      dout_q <= '0;
      pv_q   <= 1'b0;
    end else begin
      sp_q   <= sp_d;
      dout_q <= dout_d;
      pv_q   <= pv_d;
    end
  end

`ifdef SYN_LIFO_ERR_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (op == OP_FLUSH) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | ovf_evt;
      udf_q <= udf_q | udf_evt;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`else
  logic unused_evt;
  assign unused_evt = ovf_evt ^ udf_evt;
  assign ovf        = 1'b0;
  assign udf        = 1'b0;
`endif

  assign data_out     = dout_q;
  assign pop_valid    = pv_q;
  assign count        = sp_q;
  assign almost_full  = (sp_q >= AF_TH_C);
  assign almost_empty = (sp_q <= AE_TH_C);

endmodule

// File: tb/tb_syn_lifo_param.sv
// Directed self-checking bench for syn_lifo_param (depth 8, width 8, margins 1).
// Error-flag expectations follow whether SYN_LIFO_ERR_EN is defined.
module tb_syn_lifo_param;

`ifdef SYN_LIFO_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr, flush, push, pop;
  logic [7:0] data_in, data_out;
  logic       pop_valid, full, empty, almost_full, almost_empty, ovf, udf;
  logic [3:0] count;

  int total = 0;
  int bad   = 0;

  syn_lifo_param #(
    .data_width(8), .depth(8), .af_margin(1), .ae_margin(1)
  ) dut (
    .clk(clk), .clr(clr), .flush(flush), .push(push), .pop(pop),
    .data_in(data_in), .data_out(data_out), .pop_valid(pop_valid),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  // Apply one cycle of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic f, input logic pu, input logic po, input logic [7:0] d);
    flush = f; push = pu; pop = po; data_in = d;
    @(posedge clk);
    #1;
    flush = 1'b0; push = 1'b0; pop = 1'b0; data_in = 8'h00;
  endtask

  task automatic test_reset;
    clr = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; data_in = 8'h00;
    #2;
    total++;
    if ({count, data_out, pop_valid, ovf, udf} !== 15'd0 || empty !== 1'b1 ||
        full !== 1'b0 || almost_empty !== 1'b1 || almost_full !== 1'b0) begin
      bad++;
      $display("FAIL reset_init: count=%0d dout=%h pv=%b ovf=%b udf=%b empty=%b full=%b ae=%b af=%b, want 0/00/0/0/0/1/0/1/0",
               count, data_out, pop_valid, ovf, udf, empty, full, almost_empty, almost_full);
    end
    @(negedge clk); clr = 1'b1;
    cyc(0, 1, 0, 8'h77);
    cyc(0, 1, 0, 8'h78);
    cyc(0, 0, 1, 8'h00);
    total++;
    if (data_out !== 8'h78 || pop_valid !== 1'b1 || count !== 4'd1) begin
      bad++;
      $display("FAIL pre_reset_pop: dout=%h pv=%b count=%0d, want 78/1/1", data_out, pop_valid, count);
    end
    #1 clr = 1'b0;
    #1;
    total++;
    if (count !== 4'd0 || data_out !== 8'h00 || pop_valid !== 1'b0 || empty !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: count=%0d dout=%h pv=%b empty=%b, want 0/00/0/1", count, data_out, pop_valid, empty);
    end
    @(negedge clk); clr = 1'b1;
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 0, 8'(i));
      total++;
      if (count !== 4'(i) || almost_full !== (i >= 7) || full !== (i == 8) ||
          almost_empty !== (i <= 1) || empty !== 1'b0 || pop_valid !== 1'b0) begin
        bad++;
        $display("FAIL fill_%0d: count=%0d af=%b full=%b ae=%b empty=%b pv=%b, want %0d/%b/%b/%b/0/0",
                 i, count, almost_full, full, almost_empty, empty, pop_valid,
                 i, (i >= 7), (i == 8), (i <= 1));
      end
    end
  endtask

  task automatic test_drain;
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 1, 8'h00);
      total++;
      if (data_out !== 8'(9 - i) || pop_valid !== 1'b1 || count !== 4'(8 - i) || empty !== (i == 8)) begin
        bad++;
        $display("FAIL drain_%0d: dout=%h pv=%b count=%0d empty=%b, want %h/1/%0d/%b",
                 i, data_out, pop_valid, count, empty, 8'(9 - i), 8 - i, (i == 8));
      end
    end
    cyc(0, 0, 1, 8'h00);
    total++;
    if (data_out !== 8'h01 || pop_valid !== 1'b0 || count !== 4'd0 || udf !== ERR || ovf !== 1'b0) begin
      bad++;
      $display("FAIL underflow: dout=%h pv=%b count=%0d udf=%b ovf=%b, want 01/0/0/%b/0",
               data_out, pop_valid, count, udf, ovf, ERR);
    end
  endtask

  task automatic test_overflow;
    for (int i = 1; i <= 8; i++) cyc(0, 1, 0, 8'(i));
    cyc(0, 1, 0, 8'hAA);
    total++;
    if (count !== 4'd8 || full !== 1'b1 || ovf !== ERR) begin
      bad++;
      $display("FAIL overflow: count=%0d full=%b ovf=%b, want 8/1/%b", count, full, ovf, ERR);
    end
    cyc(0, 0, 1, 8'h00);
    total++;
    if (data_out !== 8'h08 || count !== 4'd7 || ovf !== ERR || udf !== ERR) begin
      bad++;
      $display("FAIL ovf_pop: dout=%h count=%0d ovf=%b udf=%b, want 08/7/%b/%b", data_out, count, ovf, udf, ERR, ERR);
    end
  endtask

  task automatic test_exchange;
    cyc(1, 0, 0, 8'h00);
    total++;
    if (count !== 4'd0 || ovf !== 1'b0 || udf !== 1'b0 || data_out !== 8'h08 || pop_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_clear: count=%0d ovf=%b udf=%b dout=%h pv=%b, want 0/0/0/08/0",
               count, ovf, udf, data_out, pop_valid);
    end
    cyc(0, 1, 0, 8'h11);
    cyc(0, 1, 0, 8'h22);
    cyc(0, 1, 1, 8'h33);
    total++;
    if (data_out !== 8'h22 || pop_valid !== 1'b1 || count !== 4'd2) begin
      bad++;
      $display("FAIL exchange: dout=%h pv=%b count=%0d, want 22/1/2", data_out, pop_valid, count);
    end
    cyc(0, 0, 1, 8'h00);
    total++;
    if (data_out !== 8'h33 || count !== 4'd1) begin
      bad++;
      $display("FAIL xchg_pop1: dout=%h count=%0d, want 33/1", data_out, count);
    end
    cyc(0, 0, 1, 8'h00);
    total++;
    if (data_out !== 8'h11 || count !== 4'd0 || empty !== 1'b1) begin
      bad++;
      $display("FAIL xchg_pop2: dout=%h count=%0d empty=%b, want 11/0/1", data_out, count, empty);
    end
  endtask

  task automatic test_bypass_flush;
    cyc(0, 1, 1, 8'h5C);
    total++;
    if (data_out !== 8'h5C || pop_valid !== 1'b1 || count !== 4'd0 || udf !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL bypass: dout=%h pv=%b count=%0d udf=%b ovf=%b, want 5C/1/0/0/0",
               data_out, pop_valid, count, udf, ovf);
    end
    cyc(0, 0, 0, 8'h00);
    total++;
    if (data_out !== 8'h5C || pop_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_hold: dout=%h pv=%b, want 5C/0", data_out, pop_valid);
    end
    cyc(0, 1, 0, 8'hA1);
    cyc(0, 1, 0, 8'hA2);
    cyc(0, 1, 0, 8'hA3);
    cyc(1, 1, 1, 8'hEE);
    total++;
    if (count !== 4'd0 || ovf !== 1'b0 || udf !== 1'b0 || data_out !== 8'h5C || pop_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush: count=%0d ovf=%b udf=%b dout=%h pv=%b, want 0/0/0/5C/0",
               count, ovf, udf, data_out, pop_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] vals [4] = '{8'h3C, 8'hC3, 8'h00, 8'hFF};
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, vals[i]);
      cyc(0, 0, 1, 8'h00);
      total++;
      if (data_out !== vals[i] || pop_valid !== 1'b1 || count !== 4'd0) begin
        bad++;
        $display("FAIL b2b_%0d: dout=%h pv=%b count=%0d, want %h/1/0", i, data_out, pop_valid, count, vals[i]);
      end
    end
    // Exchange on a full stack leaves occupancy at depth.
    for (int i = 1; i <= 8; i++) cyc(0, 1, 0, 8'(8'h40 + i));
    cyc(0, 1, 1, 8'h99);
    total++;
    if (data_out !== 8'h48 || count !== 4'd8 || full !== 1'b1 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL full_xchg: dout=%h count=%0d full=%b ovf=%b, want 48/8/1/0", data_out, count, full, ovf);
    end
    cyc(0, 0, 1, 8'h00);
    total++;
    if (data_out !== 8'h99 || count !== 4'd7) begin
      bad++;
      $display("FAIL full_xchg_pop: dout=%h count=%0d, want 99/7", data_out, count);
    end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_drain;
    test_overflow;
    test_exchange;
    test_bypass_flush;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
